// File: rtl/seq_sub64_slice_if.sv
// Start/done handshake bundle for the sliced subtractor.
// SUB_ZERO_FLAG_EN adds the registered zero result flag.
interface seq_sub64_slice_if #(
  parameter int WIDTH = 64
);
  logic             start;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             borrow_in;
  logic [WIDTH-1:0] z;
  logic             borrow_out;
  logic             overflow;
  logic             busy;
  logic             done;
`ifdef SUB_ZERO_FLAG_EN
  logic             zero;
`endif

  modport master (
    output start, x, y, borrow_in,
`ifdef SUB_ZERO_FLAG_EN
    input  zero,
`endif
    input  z, borrow_out, overflow, busy, done
  );

  modport slave (
    input  start, x, y, borrow_in,
`ifdef SUB_ZERO_FLAG_EN
    output zero,
`endif
    output z, borrow_out, overflow, busy, done
  );
endinterface

// File: rtl/seq_sub64_slice.sv
// Multi-cycle subtractor: one SLICE-bit slice per clock, registered borrow.
// Optional SUB_ZERO_FLAG_EN adds a zero flag built from a sticky slice OR.
module seq_sub64_slice #(
  parameter int WIDTH = 64,
  parameter int SLICE = 8
) (
  input  logic              clk,
  input  logic              rst,
  seq_sub64_slice_if.slave  bus
);
  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_n;

  logic [WIDTH-1:0] xr, yr, zr;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             bo, ov;
  logic             busy_c, done_c;
  logic [SLICE-1:0] xs, ys;
  logic [SLICE:0]   sum;
  logic             last;
  logic             accept;

  assign xs     = xr[cnt*SLICE +: SLICE];
  assign ys     = yr[cnt*SLICE +: SLICE];
  // x + ~y + carry, where carry starts as ~borrow_in
  assign sum    = {1'b0, xs} + {1'b0, ~ys} + {{SLICE{1'b0}}, carry};
  assign last   = (cnt == CW'(NSLICE - 1));
  assign accept = (state == IDLE) && bus.start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    busy_c  = 1'b0;
    done_c  = 1'b0;
    unique case (state)
      IDLE: if (bus.start) state_n = RUN;
      RUN: begin
        busy_c = 1'b1;
        if (last) state_n = DONE;
      end
      DONE: begin
        done_c  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xr    <= '0;
      yr    <= '0;
      zr    <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      bo    <= 1'b0;
      ov    <= 1'b0;
    end else if (accept) begin
      xr    <= bus.x;
      yr    <= bus.y;
      zr    <= '0;
      cnt   <= '0;
      carry <= ~bus.borrow_in;
    end else if (state == RUN) begin
      zr[cnt*SLICE +: SLICE] <= sum[SLICE-1:0];
      carry <= sum[SLICE];
      cnt   <= last ? '0 : cnt + CW'(1);
      if (last) begin
        bo <= ~sum[SLICE];
        ov <= (xr[WIDTH-1] ^ yr[WIDTH-1]) &
              (sum[SLICE-1] ^ xr[WIDTH-1]);
      end
    end
  end

`ifdef SUB_ZERO_FLAG_EN
  logic nz, zf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nz <= 1'b0;
      zf <= 1'b0;
    end else if (accept) begin
      nz <= 1'b0;
    end else if (state == RUN) begin
      nz <= nz | (|sum[SLICE-1:0]);
      if (last) zf <= ~(nz | (|sum[SLICE-1:0]));
    end
  end

  assign bus.zero = zf;
`endif

  assign bus.z          = zr;
  assign bus.borrow_out = bo;
  assign bus.overflow   = ov;
  assign bus.busy       = busy_c;
  assign bus.done       = done_c;
endmodule

// File: tb/tb_seq_sub64_slice.sv
// Directed + table-driven + random bench for seq_sub64_slice.
// Define SUB_ZERO_FLAG_EN to also exercise the zero flag.
module tb_seq_sub64_slice;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   passed = 0;
  logic prev_b = 1'b0;
  logic prev_o = 1'b0;

  always #5 clk = ~clk;

  seq_sub64_slice_if #(.WIDTH(64)) bus ();

  seq_sub64_slice #(.WIDTH(64), .SLICE(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [63:0] x;
    logic [63:0] y;
    logic        bi;
    logic [63:0] ez;
    logic        eb;
    logic        eo;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic run_op(input string nm, input logic [63:0] a,
                        input logic [63:0] b, input logic bi,
                        input logic [63:0] ez, input logic eb,
                        input logic eo);
    int cyc;
    @(negedge clk);
    bus.start = 1'b1;
    bus.x = a;
    bus.y = b;
    bus.borrow_in = bi;
    @(negedge clk);
    bus.start = 1'b0;
    bus.x = ~a;
    bus.y = ~b;
    bus.borrow_in = ~bi;
    check({nm, " busy"}, 64'(bus.busy), 64'd1);
    check({nm, " zclr"}, bus.z, 64'd0);
    check({nm, " bhold"}, 64'(bus.borrow_out), 64'(prev_b));
    check({nm, " ohold"}, 64'(bus.overflow), 64'(prev_o));
    cyc = 0;
    while (!bus.done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check({nm, " lat"}, 64'(cyc), 64'd8);
    check({nm, " z"}, bus.z, ez);
    check({nm, " bo"}, 64'(bus.borrow_out), 64'(eb));
    check({nm, " ov"}, 64'(bus.overflow), 64'(eo));
    check({nm, " busy0"}, 64'(bus.busy), 64'd0);
`ifdef SUB_ZERO_FLAG_EN
    check({nm, " zero"}, 64'(bus.zero), 64'(ez == 64'd0));
`endif
    @(negedge clk);
    check({nm, " pulse"}, 64'(bus.done), 64'd0);
    check({nm, " zhold"}, bus.z, ez);
    prev_b = eb;
    prev_o = eo;
  endtask

  initial begin
    logic [63:0] ra, rb, rz;
    logic [64:0] full;
    logic        rbi, ro;
    int          ndone, cyc;

    tbl[0] = '{64'd1000, 64'd1, 1'b0, 64'd999, 1'b0, 1'b0};
    tbl[1] = '{64'd0, 64'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
    tbl[2] = '{64'h0000_0001_0000_0000, 64'd0, 1'b1,
               64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0};
    tbl[3] = '{64'h8000_0000_0000_0000, 64'd1, 1'b0,
               64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1};
    tbl[4] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
               64'h8000_0000_0000_0000, 1'b1, 1'b1};
    tbl[5] = '{64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b0,
               64'd0, 1'b0, 1'b0};
    tbl[6] = '{64'd5, 64'd3, 1'b1, 64'd1, 1'b0, 1'b0};

    bus.start = 1'b0;
    bus.x = '0;
    bus.y = '0;
    bus.borrow_in = 1'b0;
    #1;
    check("rst z", bus.z, 64'd0);
    check("rst busy", 64'(bus.busy), 64'd0);
    check("rst done", 64'(bus.done), 64'd0);
    check("rst bo", 64'(bus.borrow_out), 64'd0);
`ifdef SUB_ZERO_FLAG_EN
    check("rst zero", 64'(bus.zero), 64'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++)
      run_op($sformatf("tbl%0d", i), tbl[i].x, tbl[i].y, tbl[i].bi,
             tbl[i].ez, tbl[i].eb, tbl[i].eo);

    // leave borrow/overflow set, then reset in the middle of a run
    run_op("prep", 64'd0, 64'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    @(negedge clk);
    bus.start = 1'b1;
    bus.x = 64'hFFFF_FFFF_FFFF_FFFF;
    bus.y = 64'd1;
    bus.borrow_in = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid z", bus.z, 64'h0000_0000_0000_FFFE);
    @(posedge clk);
    rst = 1'b1;
    #1;
    check("mrst z", bus.z, 64'd0);
    check("mrst busy", 64'(bus.busy), 64'd0);
    check("mrst done", 64'(bus.done), 64'd0);
    check("mrst bo", 64'(bus.borrow_out), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    prev_b = 1'b0;
    prev_o = 1'b0;
    run_op("post", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0,
           64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);

    // start pulsed during RUN must be ignored
    @(negedge clk);
    bus.start = 1'b1;
    bus.x = 64'd10;
    bus.y = 64'd4;
    bus.borrow_in = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    ndone = 0;
    for (cyc = 1; cyc <= 16; cyc++) begin
      if (cyc == 3) begin
        bus.start = 1'b1;
        bus.x = 64'd5;
        bus.y = 64'd3;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      if (bus.done) begin
        ndone++;
        check("ign lat", 64'(cyc), 64'd8);
        check("ign z", bus.z, 64'd6);
      end
    end
    check("ign ndone", 64'(ndone), 64'd1);
    check("ign hold", bus.z, 64'd6);
    check("ign idle", 64'(bus.busy), 64'd0);
    prev_b = 1'b0;
    prev_o = 1'b0;

    for (int i = 0; i < 50; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (i == 0) rb = ra;
      rbi = 1'($urandom);
      full = {1'b0, ra} - {1'b0, rb} - {64'd0, rbi};
      rz = full[63:0];
      ro = (ra[63] != rb[63]) && (rz[63] != ra[63]);
      run_op($sformatf("rnd%0d", i), ra, rb, rbi, rz, full[64], ro);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
